// File: rtl/dcache_ctrl_pkg.sv
// Shared definitions for the direct-mapped write-back data cache:
// state encoding, address field widths and big-endian word helpers.
package dcache_ctrl_pkg;

  localparam int DC_WORD_BITS  = 32;
  localparam int DC_BLOCK_BITS = 1024;
  localparam int DC_NUM_LINES  = 8;
  localparam int OFFSET_BITS   = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_WB,
    ST_FILL_REQ,
    ST_FILL_WAIT,
    ST_FL_SCAN,
    ST_FL_DONE
  } state_t;

  function automatic int index_bits(input int num_lines);
    return (num_lines > 1) ? $clog2(num_lines) : 1;
  endfunction

  function automatic int tag_bits(input int num_lines);
    return DC_WORD_BITS - OFFSET_BITS - index_bits(num_lines);
  endfunction

  // Byte 0 of the line sits in the most significant byte lane.
  function automatic logic [DC_WORD_BITS-1:0] word_sel(
    input logic [DC_BLOCK_BITS-1:0] line,
    input logic [OFFSET_BITS-1:0]   off
  );
    return line[DC_BLOCK_BITS-1-8*int'(off) -: DC_WORD_BITS];
  endfunction

  function automatic logic [DC_BLOCK_BITS-1:0] word_merge(
    input logic [DC_BLOCK_BITS-1:0] line,
    input logic [OFFSET_BITS-1:0]   off,
    input logic [DC_WORD_BITS-1:0]  word
  );
    logic [DC_BLOCK_BITS-1:0] l;
    l = line;
    l[DC_BLOCK_BITS-1-8*int'(off) -: DC_WORD_BITS] = word;
    return l;
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Line storage: valid/dirty flags (reset) plus tag/data (not reset).
// One combinational read port and one whole-line write port.
module dcache_array #(
  parameter int NUM_LINES  = 8,
  parameter int IDX_BITS   = 3,
  parameter int TAG_BITS   = 22,
  parameter int BLOCK_BITS = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IDX_BITS-1:0]   rd_idx,
  output logic                  rd_valid,
  output logic                  rd_dirty,
  output logic [TAG_BITS-1:0]   rd_tag,
  output logic [BLOCK_BITS-1:0] rd_data,
  input  logic                  we,
  input  logic [IDX_BITS-1:0]   wr_idx,
  input  logic                  wr_valid,
  input  logic                  wr_dirty,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic [BLOCK_BITS-1:0] wr_data
);

  logic [NUM_LINES-1:0]  valid_q;
  logic [NUM_LINES-1:0]  dirty_q;
  logic [TAG_BITS-1:0]   tag_q  [NUM_LINES];
  logic [BLOCK_BITS-1:0] data_q [NUM_LINES];

  // Line status flags; cleared by reset so every line starts invalid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (we) begin
      valid_q[wr_idx] <= wr_valid;
      dirty_q[wr_idx] <= wr_dirty;
    end
  end

  // Tag and data payload; meaningless until the valid flag is set.
  always_ff @(posedge clk) begin
    if (we) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_dirty = dirty_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// Handshake: a CPU request transfers on a cycle where req_valid and
// req_ready are both high; req_ready is high only in IDLE, and the
// completion is a single-cycle resp_valid pulse carrying resp_rdata.
module dcache_ctrl
  import dcache_ctrl_pkg::*;
#(
  parameter int WORD_BITS  = DC_WORD_BITS,
  parameter int BLOCK_BITS = DC_BLOCK_BITS,
  parameter int NUM_LINES  = DC_NUM_LINES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [WORD_BITS-1:0]  req_addr,
  input  logic [WORD_BITS-1:0]  req_wdata,
  output logic                  req_ready,
  output logic                  resp_valid,
  output logic [WORD_BITS-1:0]  resp_rdata,
  input  logic                  flush_req,
  output logic [WORD_BITS-1:0]  mem_addr,
  output logic                  mem_readable,
  output logic                  mem_writable,
  output logic [BLOCK_BITS-1:0] mem_write,
  input  logic [BLOCK_BITS-1:0] mem_out1,
  output logic                  mem_flush
);

  localparam int IDX_BITS = index_bits(NUM_LINES);
  localparam int TAG_BITS = tag_bits(NUM_LINES);

  state_t                state, state_d;
  logic [WORD_BITS-1:0]  addr_q, wdata_q;
  logic                  write_q;
  logic [IDX_BITS-1:0]   scan_idx, scan_d;
  logic                  resp_valid_d;
  logic [WORD_BITS-1:0]  resp_rdata_d;

  logic                  rd_valid, rd_dirty;
  logic [TAG_BITS-1:0]   rd_tag;
  logic [BLOCK_BITS-1:0] rd_data;
  logic [IDX_BITS-1:0]   rd_idx;
  logic                  we, wr_valid, wr_dirty;
  logic [TAG_BITS-1:0]   wr_tag;
  logic [BLOCK_BITS-1:0] wr_data;

  logic [IDX_BITS-1:0]    req_idx;
  logic [TAG_BITS-1:0]    req_tag;
  logic [OFFSET_BITS-1:0] req_off;
  logic                   accept, hit;
  logic [BLOCK_BITS-1:0]  hit_line, fill_line;
  logic                   unused_bits;

  assign req_idx     = addr_q[OFFSET_BITS +: IDX_BITS];
  assign req_tag     = addr_q[WORD_BITS-1 -: TAG_BITS];
  assign req_off     = {addr_q[OFFSET_BITS-1:2], 2'b00};
  assign unused_bits = ^addr_q[1:0];

  assign req_ready = (state == ST_IDLE);
  assign accept    = req_valid && req_ready;
  assign rd_idx    = (state == ST_FL_SCAN) ? scan_idx : req_idx;
  assign hit       = rd_valid && (rd_tag == req_tag);
  assign hit_line  = word_merge(rd_data, req_off, wdata_q);
  assign fill_line = write_q ? word_merge(mem_out1, req_off, wdata_q) : mem_out1;

  dcache_array #(
    .NUM_LINES  (NUM_LINES),
    .IDX_BITS   (IDX_BITS),
    .TAG_BITS   (TAG_BITS),
    .BLOCK_BITS (BLOCK_BITS)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (rd_idx),
    .rd_valid (rd_valid),
    .rd_dirty (rd_dirty),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .we       (we),
    .wr_idx   (rd_idx),
    .wr_valid (wr_valid),
    .wr_dirty (wr_dirty),
    .wr_tag   (wr_tag),
    .wr_data  (wr_data)
  );

  // State, request latch, flush scan index and registered response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      scan_idx   <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      write_q    <= 1'b0;
    end else begin
      state      <= state_d;
      scan_idx   <= scan_d;
      resp_valid <= resp_valid_d;
      resp_rdata <= resp_rdata_d;
      if (accept) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        write_q <= req_write;
      end
    end
  end

  // Next state, array update and memory strobes; strobes are decoded
  // from the current state so each lasts exactly one cycle.
  always_comb begin
    state_d      = state;
    scan_d       = scan_idx;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata;
    we           = 1'b0;
    wr_valid     = rd_valid;
    wr_dirty     = rd_dirty;
    wr_tag       = rd_tag;
    wr_data      = rd_data;
    mem_addr     = '0;
    mem_readable = 1'b0;
    mem_writable = 1'b0;
    mem_write    = '0;
    mem_flush    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_LOOKUP;
        end else if (flush_req) begin
          state_d = ST_FL_SCAN;
          scan_d  = '0;
        end
      end
      ST_LOOKUP: begin
        if (hit) begin
          resp_valid_d = 1'b1;
          resp_rdata_d = write_q ? wdata_q : word_sel(rd_data, req_off);
          if (write_q) begin
            we       = 1'b1;
            wr_dirty = 1'b1;
            wr_data  = hit_line;
          end
          state_d = ST_IDLE;
        end else if (rd_valid && rd_dirty) begin
          state_d = ST_WB;
        end else begin
          state_d = ST_FILL_REQ;
        end
      end
      ST_WB: begin
        mem_writable = 1'b1;
        mem_addr     = {rd_tag, req_idx, {OFFSET_BITS{1'b0}}};
        mem_write    = rd_data;
        we           = 1'b1;
        wr_dirty     = 1'b0;
        state_d      = ST_FILL_REQ;
      end
      ST_FILL_REQ: begin
        mem_readable = 1'b1;
        mem_addr     = {req_tag, req_idx, {OFFSET_BITS{1'b0}}};
        state_d      = ST_FILL_WAIT;
      end
      ST_FILL_WAIT: begin
        we           = 1'b1;
        wr_valid     = 1'b1;
        wr_tag       = req_tag;
        wr_dirty     = write_q;
        wr_data      = fill_line;
        resp_valid_d = 1'b1;
        resp_rdata_d = word_sel(fill_line, req_off);
        state_d      = ST_IDLE;
      end
      ST_FL_SCAN: begin
        if (rd_valid && rd_dirty) begin
          mem_writable = 1'b1;
          mem_addr     = {rd_tag, scan_idx, {OFFSET_BITS{1'b0}}};
          mem_write    = rd_data;
          we           = 1'b1;
          wr_dirty     = 1'b0;
        end
        scan_d = scan_idx + 1'b1;
        if (scan_idx == IDX_BITS'(NUM_LINES - 1)) state_d = ST_FL_DONE;
      end
      ST_FL_DONE: begin
        mem_flush = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: memory responder, line-level cache model and a
// flat word-memory model that predict latency, strobes and data.
module tb_dcache_ctrl;

  localparam int NL = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_write, req_ready, resp_valid, flush_req;
  logic [31:0]   req_addr, req_wdata, resp_rdata, mem_addr;
  logic          mem_readable, mem_writable, mem_flush;
  logic [1023:0] mem_write;
  logic [1023:0] mem_out1 = '0;

  int n_tests = 0;
  int n_fail  = 0;

  // Memory behind the cache, and the word image the CPU should observe.
  logic [1023:0] mem_lines [int unsigned];
  logic [31:0]   gold      [int unsigned];

  // Which line address each cache slot holds, and whether it is modified.
  bit          m_valid [NL];
  bit          m_dirty [NL];
  int unsigned m_la    [NL];

  always #5 clk = ~clk;

  dcache_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_ready    (req_ready),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .flush_req    (flush_req),
    .mem_addr     (mem_addr),
    .mem_readable (mem_readable),
    .mem_writable (mem_writable),
    .mem_write    (mem_write),
    .mem_out1     (mem_out1),
    .mem_flush    (mem_flush)
  );

  function automatic logic [31:0] init_word(input int unsigned a);
    if (a == 32'h104) return 32'hDEADBEEF;
    return (a * 32'h9E3779B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] exp_word(input int unsigned a);
    if (gold.exists(a)) return gold[a];
    return init_word(a);
  endfunction

  function automatic logic [1023:0] env_line(input int unsigned la);
    logic [1023:0] l;
    if (mem_lines.exists(la)) return mem_lines[la];
    for (int k = 0; k < 32; k++) l[1023-32*k -: 32] = init_word(la + 4*k);
    return l;
  endfunction

  function automatic logic [1023:0] gold_line(input int unsigned la);
    logic [1023:0] l;
    for (int k = 0; k < 32; k++) l[1023-32*k -: 32] = exp_word(la + 4*k);
    return l;
  endfunction

  // Memory side: line read data appears the cycle after mem_readable.
  always @(negedge clk) begin
    if (mem_writable) mem_lines[mem_addr] = mem_write;
    if (mem_readable) mem_out1 = env_line(mem_addr);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NL; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
      m_la[i]    = 0;
    end
  endtask

  // Issue one request at a negedge and follow it to its response.
  task automatic do_req(input bit w, input int unsigned a, input logic [31:0] wd,
                        input bit fl, output logic [1023:0] wb_line);
    int unsigned la, slot, victim, rd_addr, wr_addr;
    bit          hit, dmiss, got_resp;
    int          exp_lat, lat, n_rd, n_wr, guard;
    logic [1023:0] exp_wb;
    logic [31:0] exp_rd, rdata;
    la      = a & ~32'd127;
    slot    = (a >> 7) % NL;
    hit     = m_valid[slot] && (m_la[slot] == la);
    dmiss   = !hit && m_valid[slot] && m_dirty[slot];
    victim  = m_la[slot];
    exp_lat = hit ? 2 : (dmiss ? 5 : 4);
    exp_wb  = dmiss ? gold_line(victim) : '0;
    exp_rd  = exp_word(a & ~32'd3);
    wb_line = '0;
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("ready_before_req", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = wd;
    flush_req = fl;
    @(negedge clk);
    req_valid = 1'b0;
    req_write = 1'b0;
    lat = 1; n_rd = 0; n_wr = 0; got_resp = 1'b0;
    rd_addr = 0; wr_addr = 0; rdata = '0;
    while (lat <= 12) begin
      check("strobe_exclusive", 32'(mem_readable & mem_writable), 32'd0);
      if (mem_readable) begin n_rd++; rd_addr = mem_addr; end
      if (mem_writable) begin n_wr++; wr_addr = mem_addr; wb_line = mem_write; end
      if (resp_valid) begin
        got_resp = 1'b1;
        rdata = resp_rdata;
        break;
      end
      @(negedge clk);
      lat++;
    end
    check("resp_seen", 32'(got_resp), 32'd1);
    check("latency", 32'(lat), 32'(exp_lat));
    check("n_read_strobes", 32'(n_rd), hit ? 32'd0 : 32'd1);
    check("n_write_strobes", 32'(n_wr), dmiss ? 32'd1 : 32'd0);
    if (!hit) check("fill_addr", rd_addr, la);
    if (dmiss) begin
      check("wb_addr", wr_addr, victim);
      check("wb_line_ok", 32'(wb_line == exp_wb), 32'd1);
    end
    if (!w) check("load_data", rdata, exp_rd);
    if (w) gold[a & ~32'd3] = wd;
    m_dirty[slot] = hit ? (m_dirty[slot] | w) : w;
    m_valid[slot] = 1'b1;
    m_la[slot]    = la;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1023:0] wl;
    int wcount, first_flush, flush_cycles, n_dirty, bad;
    int unsigned slot, a;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0;
    req_addr = '0; req_wdata = '0; flush_req = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state.
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_strobes", 32'({mem_readable, mem_writable, mem_flush}), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_write_zero", 32'(mem_write == '0), 32'd1);

    // Directed: cold miss, hit, store hit, load hit, dirty eviction.
    do_req(1'b0, 32'h104, 32'h0, 1'b0, wl);
    do_req(1'b0, 32'h104, 32'h0, 1'b0, wl);
    do_req(1'b1, 32'h108, 32'h12345678, 1'b0, wl);
    do_req(1'b0, 32'h108, 32'h0, 1'b0, wl);
    check("dirty_after_store", 32'(m_dirty[2]), 32'd1);
    do_req(1'b0, 32'h504, 32'h0, 1'b0, wl);
    check("wb_bytes_8_11", wl[1023-64 -: 32], 32'h12345678);

    // Reset while the refill is in flight.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h104;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("rst_test_fill_req", 32'(mem_readable), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_resp", 32'(resp_valid), 32'd0);
    check("rst_mid_ready", 32'(req_ready), 32'd1);
    check("rst_mid_strobes", 32'({mem_readable, mem_writable}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (3) begin
      @(negedge clk);
      check("post_rst_quiet", 32'({resp_valid, mem_readable, mem_writable}), 32'd0);
    end
    do_req(1'b0, 32'h104, 32'h0, 1'b0, wl);

    // Random traffic over four tags per index to force hits and evictions.
    for (int i = 0; i < 250; i++) begin
      a = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 7) << 7) | ($urandom_range(0, 31) << 2);
      do_req(1'($urandom_range(0, 1)), a, $urandom, 1'b0, wl);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    do_req(1'b1, 32'h000, 32'hA5A5_0001, 1'b0, wl);
    do_req(1'b1, 32'h380, 32'hA5A5_0002, 1'b0, wl);

    // Request together with flush: the request goes first, then the scan.
    do_req(1'b1, 32'h184, 32'hC0DE_0003, 1'b1, wl);
    n_dirty = 0;
    for (int i = 0; i < NL; i++) if (m_valid[i] && m_dirty[i]) n_dirty++;
    wcount = 0; first_flush = -1; flush_cycles = 0;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      check("flush_no_read", 32'(mem_readable), 32'd0);
      if (mem_writable) begin
        wcount++;
        slot = (mem_addr >> 7) % NL;
        check("flush_wb_target",
              32'(m_valid[slot] && m_dirty[slot] && (m_la[slot] == mem_addr)), 32'd1);
        check("flush_wb_data", 32'(mem_write == gold_line(mem_addr)), 32'd1);
        m_dirty[slot] = 1'b0;
      end
      if (mem_flush) begin
        if (first_flush < 0) first_flush = c;
        flush_cycles++;
      end
    end
    flush_req = 1'b0;
    check("flush_wb_count", 32'(wcount), 32'(n_dirty));
    check("flush_start_cycle", 32'(first_flush), 32'd9);
    check("flush_held", 32'(flush_cycles), 32'd7);
    check("flush_ready_low", 32'(req_ready), 32'd0);

    // Every store must have reached memory by now.
    bad = 0;
    foreach (gold[k]) begin
      wl = env_line(k & ~32'd127);
      if (wl[1023-8*int'(k & 32'd127) -: 32] !== gold[k]) bad++;
    end
    check("memory_image_mismatches", 32'(bad), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate data cache controller; initiator side of the block-memory interface (line address plus read/write strobes, one-line write bus, line read bus).
- Sits between the CPU load/store unit and the data memory; converts 32-bit word requests into whole-line refills and writebacks.
- On a flush request it writes back every dirty line, then raises the memory flush strobe that dumps memory contents and ends simulation.

Parameters:
- WORD_BITS, 32, CPU address/data width (`WORD_SIZE).
- BLOCK_BITS, 1024, line width in bits (`BLOCK_SIZE); 128 bytes, matching memory's 128-byte alignment.
- NUM_LINES, 8, number of cache lines; power of two.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  CPU request present.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  WORD_BITS  byte address; bits [1:0] ignored.
- req_wdata  in  WORD_BITS  store data.
- req_ready  out  1  controller can accept a request (state IDLE).
- resp_valid  out  1  one-cycle pulse: request done.
- resp_rdata  out  WORD_BITS  load data, valid with resp_valid.
- flush_req  in  1  write back all dirty lines, then end simulation.
- mem_addr  out  WORD_BITS  line-aligned byte address (low 7 bits zero).
- mem_readable  out  1  memory line-read strobe.
- mem_writable  out  1  memory line-write strobe.
- mem_write  out  BLOCK_BITS  line data to write.
- mem_out1  in  BLOCK_BITS  line read data; valid the cycle after mem_readable.
- mem_flush  out  1  memory dump/finish strobe.

Behaviour:
- Address split: offset [6:0]; index [6+log2(NUM_LINES):7]; tag = remaining upper bits.
- Per line: valid, dirty, tag, data.
- Line byte order is big-endian. Byte k occupies bits [BLOCK_BITS-1-8k -: 8]. The word at word-aligned offset o is bits [BLOCK_BITS-1-8o -: 32].
- Reset: all valid and dirty bits cleared; state IDLE; req_ready=1. resp_valid, mem_readable, mem_writable, mem_flush, mem_addr, mem_write and resp_rdata all 0. Data arrays are not reset.
- Handshake: a request is accepted when req_valid && req_ready. Address, write flag and data are latched; req_ready drops the next cycle.
- State machine:
  - IDLE: accept request -> LOOKUP. flush_req (when no request is accepted) -> FL_SCAN with scan index 0. A request accepted in the same cycle as flush_req wins; flush is taken on a later IDLE cycle if still high.
  - LOOKUP, hit (valid && tag match): load returns the word; store merges the word and sets dirty. resp_valid pulses; -> IDLE. Hit latency is 2 cycles from acceptance.
  - LOOKUP, miss with victim dirty -> WB. Miss with victim clean or invalid -> FILL_REQ.
  - WB: one cycle of mem_writable=1, mem_addr={victim tag, index, 7'b0}, mem_write=victim line; clear dirty -> FILL_REQ.
  - FILL_REQ: one cycle of mem_readable=1, mem_addr = request line address -> FILL_WAIT.
  - FILL_WAIT: capture mem_out1 into the line; set valid and tag; set dirty=0, or dirty=1 with the store merged. resp_valid pulses with load data taken from the fill -> IDLE.
  - Miss latency: clean miss 4 cycles, dirty miss 5 cycles from acceptance.
  - FL_SCAN: if line[idx] is valid and dirty, issue a one-cycle writeback (as in WB) and clear dirty. Advance idx every cycle. After idx = NUM_LINES-1 -> FL_DONE.
  - FL_DONE: mem_flush held at 1; terminal state (left only by rst).
- Strobes: mem_readable and mem_writable are never high together, and each is high for exactly one cycle per operation.
- Reset mid-operation: returns to IDLE immediately with all lines invalid. A pending response is dropped and no strobe is emitted after rst.

Decomposition:
- Shared package/define header: state encodings; OFFSET_BITS=7; index and tag width functions derived from NUM_LINES; BIG_ENDIAN word select/merge helpers.
- One natural sub-module, dcache_array: tag/valid/dirty/data storage with read-index and write-enable/merge ports. The controller FSM stays in dcache_ctrl.

Test Plan:
- Cold load 0x00000104, memory line 0x100 holding 0xDEADBEEF at byte offset 4 -> one mem_readable with mem_addr=0x00000100; resp_valid 4 cycles after accept; resp_rdata=0xDEADBEEF.
- Repeat the same load -> hit; resp_valid 2 cycles after accept; no mem strobe.
- Store 0x12345678 to 0x00000108, then load 0x00000108 -> both hit; data 0x12345678; line marked dirty; no mem_writable.
- Load 0x00000504 (same index, NUM_LINES=8) after the dirty store -> mem_writable with mem_addr=0x100 and bits for bytes 8..11 equal to 0x12345678; next cycle mem_readable with mem_addr=0x500; resp after 5 cycles.
- Two dirty lines, then flush_req -> exactly two mem_writable pulses during an 8-cycle scan, then mem_flush=1 held.
- Assert rst during FILL_WAIT -> no resp_valid; req_ready=1 next cycle; the following load of the same address misses again.
